// File: rtl/param_ram_pkg.sv
// ---------------------------------------------------------------------------
// param_ram_pkg
// Shared definitions for the parametrised CPU data/program memory:
//   - ramState_e    : sequencer states (IDLE / CLEAR)
//   - DEF_DATA_W    : default word width (14 bits, matches the CPU datapath)
//   - DEF_ADDR_W    : default word-address width (6 bits)
//   - DEF_DEPTH     : default number of implemented words
//   - DEF_INIT_FILE : default program image loaded at time zero
// ---------------------------------------------------------------------------
package param_ram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ramState_e;

    localparam int    DEF_DATA_W    = 14;
    localparam int    DEF_ADDR_W    = 6;
    localparam int    DEF_DEPTH     = 64;
    localparam string DEF_INIT_FILE = "program.mem";

endpackage

// File: rtl/param_ram_rdpipe.sv
// ---------------------------------------------------------------------------
// param_ram_rdpipe
// Read-response pipeline: RD_LAT stages of valid/data. Stage 1 captures the
// word read from the array at the accept edge; the last stage drives the
// response. Data in each stage only moves when a valid word moves into it,
// so the response data holds between pulses.
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset (flushes all stages)
//   valid_i  in   a read was accepted this cycle
//   data_i   in   array word (or 0 for an out-of-range read)
//   valid_o  out  response pulse
//   data_o   out  response data, held until the next pulse
// ---------------------------------------------------------------------------
module param_ram_rdpipe #(
    parameter int DATA_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [RD_LAT-1:0] valid_q;
    logic [DATA_W-1:0] data_q [RD_LAT];

    // Shift register; each stage's data only loads alongside a valid bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign valid_o = valid_q[RD_LAT-1];
    assign data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/param_ram.sv
// ---------------------------------------------------------------------------
// param_ram
// Single-port synchronous data/program memory for the custom CPU with a
// valid/ready request port, configurable read latency, a write-protected
// program region (words 0..PROT_DEPTH-1), out-of-range fault reporting and a
// hardware sequencer that zeroes the data region (PROT_DEPTH..DEPTH-1).
// Ports:
//   clk         in   system clock (rising edge)
//   rst         in   synchronous active-high reset; memory contents retained
//   req_valid   in   request present
//   req_ready   out  request can be accepted this cycle
//   req_we      in   1 = write, 0 = read
//   req_addr    in   word address
//   req_wdata   in   write data
//   rsp_valid   out  read data valid pulse, RD_LAT cycles after accept
//   rsp_rdata   out  read data, held until the next rsp_valid
//   fault       out  illegal-access pulse, cycle after accept
//   fault_addr  out  address of the most recent fault, held
//   clr_start   in   request a clear of the data region
//   clr_busy    out  clear sweep in progress
// ---------------------------------------------------------------------------
module param_ram
    import param_ram_pkg::*;
#(
    parameter int    DATA_W     = DEF_DATA_W,
    parameter int    ADDR_W     = DEF_ADDR_W,
    parameter int    DEPTH      = DEF_DEPTH,
    parameter int    RD_LAT     = 1,
    parameter int    PROT_DEPTH = 0,
    parameter string INIT_FILE  = DEF_INIT_FILE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    input  logic              clr_start,
    output logic              clr_busy
);

    // Bounds are widened by one bit so DEPTH == 2**ADDR_W is representable
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PROT_L   = (ADDR_W+1)'(PROT_DEPTH);
    localparam logic [ADDR_W:0] LAST_L   = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_L    = (ADDR_W+1)'(1);
    localparam bit              CLEAR_EN = (PROT_DEPTH < DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    ramState_e         state_q, state_d;
    logic [ADDR_W:0]   clrPtr_q, clrPtr_d;
    logic              fault_q;
    logic [ADDR_W-1:0] faultAddr_q;

    logic              accept;
    logic              inRange;
    logic              inProt;
    logic              writable;
    logic              faultEvt;
    logic              rdValid;
    logic [DATA_W-1:0] rdData;

    // Requests are refused while clearing, while a clear is being requested,
    // and while reset is held
    assign req_ready = ~rst & (state_q == IDLE) & ~clr_start;
    assign accept    = req_valid & req_ready;
    assign inRange   = {1'b0, req_addr} < DEPTH_L;

    // A zero-size protected region needs no compare at all
    generate
        if (PROT_DEPTH == 0) begin : gNoProt
            assign inProt = 1'b0;
        end else begin : gProt
            assign inProt = {1'b0, req_addr} < PROT_L;
        end
    endgenerate

    assign writable = inRange & ~inProt;
    assign faultEvt = accept & (req_we ? ~writable : ~inRange);
    assign rdValid  = accept & ~req_we;
    assign rdData   = inRange ? mem_q[req_addr] : '0;

    // Array write port; the clear sweep and request writes never coincide
    // because req_ready is low during CLEAR. The sweep write is not gated by
    // reset so the word being cleared in the reset cycle still ends up zero.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clrPtr_q[ADDR_W-1:0]] <= '0;
        end else if (accept && req_we && writable) begin
            mem_q[req_addr] <= req_wdata;
        end
    end

    // Sequencer state, clear pointer and fault reporting registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clrPtr_q    <= '0;
            fault_q     <= 1'b0;
            faultAddr_q <= '0;
        end else begin
            state_q  <= state_d;
            clrPtr_q <= clrPtr_d;
            fault_q  <= faultEvt;
            if (faultEvt) begin
                faultAddr_q <= req_addr;
            end
        end
    end

    // Clear sequencer: sweep PROT_DEPTH..DEPTH-1 once per clr_start
    always_comb begin
        state_d  = state_q;
        clrPtr_d = clrPtr_q;
        unique case (state_q)
            IDLE: begin
                if (clr_start && CLEAR_EN) begin
                    state_d  = CLEAR;
                    clrPtr_d = PROT_L;
                end
            end
            CLEAR: begin
                clrPtr_d = clrPtr_q + ONE_L;
                if (clrPtr_q == LAST_L) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign clr_busy   = (state_q == CLEAR);
    assign fault      = fault_q;
    assign fault_addr = faultAddr_q;

    param_ram_rdpipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) uRdpipe (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (rdValid),
        .data_i  (rdData),
        .valid_o (rsp_valid),
        .data_o  (rsp_rdata)
    );

endmodule

// File: tb/tb_param_ram.sv
// ---------------------------------------------------------------------------
// tb_param_ram
// Directed bench for param_ram using three instances:
//   dutA : 64 words, RD_LAT=1, no protection
//   dutB : 48 words, RD_LAT=3, no protection
//   dutC : 64 words, RD_LAT=1, words 0..15 protected
// Image contents are placed directly into the arrays at time zero.
// ---------------------------------------------------------------------------
module tb_param_ram;

    logic        clk;
    logic        rst;
    logic [2:0]  reqValid;
    logic [2:0]  reqWe;
    logic [2:0]  clrStart;
    logic [5:0]  reqAddr  [3];
    logic [13:0] reqWdata [3];

    wire  [2:0]  reqReady;
    wire  [2:0]  rspValid;
    wire  [2:0]  fault;
    wire  [2:0]  clrBusy;
    wire  [13:0] rspRdata  [3];
    wire  [5:0]  faultAddr [3];

    int checks;
    int failures;
    int busyCount;

    param_ram #(
        .DATA_W(14), .ADDR_W(6), .DEPTH(64), .RD_LAT(1), .PROT_DEPTH(0), .INIT_FILE("")
    ) dutA (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .rsp_valid(rspValid[0]), .rsp_rdata(rspRdata[0]),
        .fault(fault[0]), .fault_addr(faultAddr[0]),
        .clr_start(clrStart[0]), .clr_busy(clrBusy[0])
    );

    param_ram #(
        .DATA_W(14), .ADDR_W(6), .DEPTH(48), .RD_LAT(3), .PROT_DEPTH(0), .INIT_FILE("")
    ) dutB (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .rsp_valid(rspValid[1]), .rsp_rdata(rspRdata[1]),
        .fault(fault[1]), .fault_addr(faultAddr[1]),
        .clr_start(clrStart[1]), .clr_busy(clrBusy[1])
    );

    param_ram #(
        .DATA_W(14), .ADDR_W(6), .DEPTH(64), .RD_LAT(1), .PROT_DEPTH(16), .INIT_FILE("")
    ) dutC (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[2]), .req_ready(reqReady[2]), .req_we(reqWe[2]),
        .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]),
        .rsp_valid(rspValid[2]), .rsp_rdata(rspRdata[2]),
        .fault(fault[2]), .fault_addr(faultAddr[2]),
        .clr_start(clrStart[2]), .clr_busy(clrBusy[2])
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle before sampling
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one instance's request and clear inputs
    task automatic applyStimulus(input logic [1:0] idx, input logic valid, input logic we,
                                 input logic [5:0] addr, input logic [13:0] wdata,
                                 input logic clr);
        reqValid[idx] = valid;
        reqWe[idx]    = we;
        reqAddr[idx]  = addr;
        reqWdata[idx] = wdata;
        clrStart[idx] = clr;
    endtask

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [13:0] observed,
                               input logic [13:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Read on an RD_LAT=1 instance and compare the single response
    task automatic readCheck(input logic [1:0] idx, input logic [5:0] addr,
                             input logic [13:0] expData, input string tag);
        applyStimulus(idx, 1'b1, 1'b0, addr, 14'h0, 1'b0);
        waitCycle();
        applyStimulus(idx, 1'b0, 1'b0, 6'd0, 14'h0, 1'b0);
        checkOutput({tag, "_valid"}, 14'(rspValid[idx]), 14'd1);
        checkOutput({tag, "_data"}, rspRdata[idx], expData);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'(k), 1'b0, 1'b0, 6'd0, 14'h0, 1'b0);
        end

        // Program image stand-ins
        dutA.mem_q[5]  = 14'h0005;
        dutB.mem_q[11] = 14'h0111;
        dutB.mem_q[12] = 14'h0222;
        dutC.mem_q[0]  = 14'h2A00;
        dutC.mem_q[3]  = 14'h0C03;
        for (int i = 16; i < 64; i++) begin
            dutC.mem_q[6'(i)] = 14'(256 + i);
        end

        // Reset state
        waitCycle();
        waitCycle();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("rst_rspValid%0d", k), 14'(rspValid[k]), 14'd0);
            checkOutput($sformatf("rst_rspRdata%0d", k), rspRdata[k], 14'd0);
            checkOutput($sformatf("rst_fault%0d", k), 14'(fault[k]), 14'd0);
            checkOutput($sformatf("rst_faultAddr%0d", k), 14'(faultAddr[k]), 14'd0);
            checkOutput($sformatf("rst_clrBusy%0d", k), 14'(clrBusy[k]), 14'd0);
            checkOutput($sformatf("rst_reqReadyHeld%0d", k), 14'(reqReady[k]), 14'd0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("rst_reqReadyAfter%0d", k), 14'(reqReady[k]), 14'd1);
        end

        // dutA: image read, hold, write-then-read
        readCheck(2'd0, 6'd5, 14'h0005, "a_rd5");
        waitCycle();
        checkOutput("a_rd5_pulseEnd", 14'(rspValid[0]), 14'd0);
        checkOutput("a_rd5_hold", rspRdata[0], 14'h0005);
        applyStimulus(2'd0, 1'b1, 1'b1, 6'd7, 14'h2222, 1'b0);
        waitCycle();
        checkOutput("a_wr7_noRsp", 14'(rspValid[0]), 14'd0);
        readCheck(2'd0, 6'd7, 14'h2222, "a_raw7");

        // dutB: RD_LAT=3 back-to-back reads
        applyStimulus(2'd1, 1'b1, 1'b1, 6'd10, 14'h3FFF, 1'b0);
        waitCycle();
        applyStimulus(2'd1, 1'b1, 1'b0, 6'd10, 14'h0, 1'b0);
        waitCycle();
        applyStimulus(2'd1, 1'b1, 1'b0, 6'd11, 14'h0, 1'b0);
        waitCycle();
        checkOutput("b_lat_early", 14'(rspValid[1]), 14'd0);
        applyStimulus(2'd1, 1'b1, 1'b0, 6'd12, 14'h0, 1'b0);
        waitCycle();
        checkOutput("b_rsp1_valid", 14'(rspValid[1]), 14'd1);
        checkOutput("b_rsp1_data", rspRdata[1], 14'h3FFF);
        applyStimulus(2'd1, 1'b0, 1'b0, 6'd0, 14'h0, 1'b0);
        waitCycle();
        checkOutput("b_rsp2_valid", 14'(rspValid[1]), 14'd1);
        checkOutput("b_rsp2_data", rspRdata[1], 14'h0111);
        waitCycle();
        checkOutput("b_rsp3_valid", 14'(rspValid[1]), 14'd1);
        checkOutput("b_rsp3_data", rspRdata[1], 14'h0222);
        waitCycle();
        checkOutput("b_rsp_end", 14'(rspValid[1]), 14'd0);
        checkOutput("b_rsp_hold", rspRdata[1], 14'h0222);

        // dutB: out-of-range read and write, last legal word
        applyStimulus(2'd1, 1'b1, 1'b0, 6'd50, 14'h0, 1'b0);
        waitCycle();
        applyStimulus(2'd1, 1'b0, 1'b0, 6'd0, 14'h0, 1'b0);
        checkOutput("b_rd50_fault", 14'(fault[1]), 14'd1);
        checkOutput("b_rd50_faultAddr", 14'(faultAddr[1]), 14'd50);
        waitCycle();
        checkOutput("b_rd50_faultEnd", 14'(fault[1]), 14'd0);
        waitCycle();
        checkOutput("b_rd50_valid", 14'(rspValid[1]), 14'd1);
        checkOutput("b_rd50_data", rspRdata[1], 14'd0);
        applyStimulus(2'd1, 1'b1, 1'b1, 6'd63, 14'h1111, 1'b0);
        waitCycle();
        checkOutput("b_wr63_fault", 14'(fault[1]), 14'd1);
        checkOutput("b_wr63_faultAddr", 14'(faultAddr[1]), 14'd63);
        checkOutput("b_wr63_noRsp", 14'(rspValid[1]), 14'd0);
        applyStimulus(2'd1, 1'b1, 1'b1, 6'd47, 14'h0ABC, 1'b0);
        waitCycle();
        checkOutput("b_wr47_noFault", 14'(fault[1]), 14'd0);
        applyStimulus(2'd1, 1'b1, 1'b0, 6'd47, 14'h0, 1'b0);
        waitCycle();
        applyStimulus(2'd1, 1'b0, 1'b0, 6'd0, 14'h0, 1'b0);
        waitCycle();
        waitCycle();
        checkOutput("b_rd47_valid", 14'(rspValid[1]), 14'd1);
        checkOutput("b_rd47_data", rspRdata[1], 14'h0ABC);
        checkOutput("b_rd47_noFault", 14'(fault[1]), 14'd0);

        // dutC: protected region
        applyStimulus(2'd2, 1'b1, 1'b1, 6'd3, 14'h1234, 1'b0);
        waitCycle();
        applyStimulus(2'd2, 1'b0, 1'b0, 6'd0, 14'h0, 1'b0);
        checkOutput("c_wr3_fault", 14'(fault[2]), 14'd1);
        checkOutput("c_wr3_faultAddr", 14'(faultAddr[2]), 14'd3);
        readCheck(2'd2, 6'd3, 14'h0C03, "c_rd3");
        checkOutput("c_rd3_noFault", 14'(fault[2]), 14'd0);
        applyStimulus(2'd2, 1'b1, 1'b1, 6'd15, 14'h0555, 1'b0);
        waitCycle();
        checkOutput("c_wr15_fault", 14'(fault[2]), 14'd1);
        checkOutput("c_wr15_faultAddr", 14'(faultAddr[2]), 14'd15);
        applyStimulus(2'd2, 1'b1, 1'b1, 6'd16, 14'h0777, 1'b0);
        waitCycle();
        checkOutput("c_wr16_noFault", 14'(fault[2]), 14'd0);
        checkOutput("c_wr16_faultAddrHeld", 14'(faultAddr[2]), 14'd15);
        readCheck(2'd2, 6'd16, 14'h0777, "c_rd16");

        // dutC: clear aborted by reset during its tenth cycle
        applyStimulus(2'd2, 1'b0, 1'b0, 6'd0, 14'h0, 1'b1);
        waitCycle();
        applyStimulus(2'd2, 1'b0, 1'b0, 6'd0, 14'h0, 1'b0);
        checkOutput("c_abort_busy", 14'(clrBusy[2]), 14'd1);
        checkOutput("c_abort_notReady", 14'(reqReady[2]), 14'd0);
        repeat (9) waitCycle();
        rst = 1'b1;
        waitCycle();
        rst = 1'b0;
        #1;
        checkOutput("c_abort_busyAfter", 14'(clrBusy[2]), 14'd0);
        checkOutput("c_abort_readyAfter", 14'(reqReady[2]), 14'd1);
        readCheck(2'd2, 6'd16, 14'h0000, "c_abort_rd16");
        readCheck(2'd2, 6'd25, 14'h0000, "c_abort_rd25");
        readCheck(2'd2, 6'd26, 14'h011A, "c_abort_rd26");

        // dutC: full clear, clr_start beats a same-cycle request
        applyStimulus(2'd2, 1'b1, 1'b0, 6'd0, 14'h0, 1'b1);
        #1;
        checkOutput("c_clr_readyLow", 14'(reqReady[2]), 14'd0);
        waitCycle();
        applyStimulus(2'd2, 1'b0, 1'b0, 6'd0, 14'h0, 1'b0);
        checkOutput("c_clr_reqDropped", 14'(rspValid[2]), 14'd0);
        busyCount = 0;
        for (int i = 0; i < 200 && clrBusy[2] === 1'b1; i++) begin
            busyCount++;
            waitCycle();
        end
        checkOutput("c_clr_busyCycles", 14'(busyCount), 14'd48);
        readCheck(2'd2, 6'd16, 14'h0000, "c_clr_rd16");
        readCheck(2'd2, 6'd40, 14'h0000, "c_clr_rd40");
        readCheck(2'd2, 6'd63, 14'h0000, "c_clr_rd63");
        readCheck(2'd2, 6'd0, 14'h2A00, "c_clr_rd0");
        readCheck(2'd2, 6'd3, 14'h0C03, "c_clr_rd3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
